// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared constants and payload types for the CDB arbiter: unit indices in params,
// functional-unit and CDB payload structs in rv32i_types.
package params;
   localparam int unsigned NUM_FU     = 5;
   localparam int unsigned FU_LS      = 0;
   localparam int unsigned FU_ALU     = 1;
   localparam int unsigned FU_MUL     = 2;
   localparam int unsigned FU_DIV     = 3;
   localparam int unsigned FU_CONTROL = 4;
   localparam int unsigned PTR_W      = $clog2(NUM_FU);
   localparam int unsigned ROB_IDX_W  = 4;

   function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_FU-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (oh[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction
endpackage

package rv32i_types;
   import params::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } rvfi_data_t;

   typedef struct packed {
      logic [4:0]           rd;
      logic [5:0]           pd;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [31:0]          data;
      rvfi_data_t           rvfi_data_out;
   } funct_unit_out_t;

   typedef struct packed {
      logic [4:0]           rd;
      logic [5:0]           pd;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [31:0]          data;
      rvfi_data_t           rvfi_data_out;
   } cdb_out_t;

   function automatic cdb_out_t fu_to_cdb(input funct_unit_out_t f);
      cdb_out_t c;
      c.rd            = f.rd;
      c.pd            = f.pd;
      c.rob_idx       = f.rob_idx;
      c.data          = f.data;
      c.rvfi_data_out = f.rvfi_data_out;
      return c;
   endfunction
endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Rotating one-hot picker: grants the first set request at or after ptr, wrapping
// modulo WIDTH. With ptr held at zero it degenerates to fixed low-index priority.
module rr_pick #(
   parameter int unsigned WIDTH = 5,
   localparam int unsigned PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [WIDTH-1:0] grant
);

   logic [31:0] idx;
   logic        found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         idx = (32'(ptr) + k) % WIDTH;
         if (!found && req[idx[PW-1:0]]) begin
            grant[idx[PW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// One-deep result buffer per functional unit feeding a registered common data bus.
// Define CDB_RR_ARB_EN for round-robin selection; otherwise fixed priority ls first.
module cdb_rr_arbiter
   import params::*;
   import rv32i_types::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NUM_FU-1:0]     req_valid,
   input  funct_unit_out_t       req_entry [NUM_FU],
   output logic [NUM_FU-1:0]     req_ready,
   output logic                  cdb_valid,
   output cdb_out_t              cdb_out,
   output logic [NUM_FU-1:0]     cdb_grant
);

   logic [NUM_FU-1:0] buf_valid;
   funct_unit_out_t   buf_entry [NUM_FU];
   logic [NUM_FU-1:0] win;
   logic [NUM_FU-1:0] accept;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W-1:0]  rr_ptr;

   rr_pick #(
      .WIDTH (NUM_FU)
   ) u_pick (
      .req   (buf_valid),
      .ptr   (rr_ptr),
      .grant (win)
   );

   // A draining buffer can be refilled on the same edge it is broadcast.
   assign req_ready = flush ? '0 : (~buf_valid | win);
   assign accept    = req_valid & req_ready;
   assign win_idx   = onehot_idx(win);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= '0;
         cdb_valid <= 1'b0;
         cdb_grant <= '0;
         cdb_out   <= '0;
         for (int i = 0; i < NUM_FU; i++) buf_entry[i] <= '0;
      end else if (flush) begin
         buf_valid <= '0;
         cdb_valid <= 1'b0;
         cdb_grant <= '0;
      end else begin
         buf_valid <= (buf_valid & ~win) | accept;
         cdb_valid <= |win;
         cdb_grant <= win;
         if (|win) cdb_out <= fu_to_cdb(buf_entry[win_idx]);
         for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) buf_entry[i] <= req_entry[i];
         end
      end
   end

`ifdef CDB_RR_ARB_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (!flush && |win) begin
         rr_ptr <= (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
      end
   end
`else
   assign rr_ptr = '0;
`endif

endmodule

// File: doc/cdb_rr_arbiter.md
CDB_RR_ARBITER -- requirements
Module: cdb_rr_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush, input, 1, mispredict flush; squashes all buffered results.
REQ-004 SHALL have port req_valid, input, [NUM_FU], per-unit result valid; index order ls=0, alu=1, mul=2, div=3, control=4.
REQ-005 SHALL have port req_entry, input, funct_unit_out_t [NUM_FU], per-unit result payload.
REQ-006 SHALL have port req_ready, output, [NUM_FU], per-unit accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at the clock edge.
REQ-007 SHALL have port cdb_valid, output, 1, registered CDB broadcast valid.
REQ-008 SHALL have port cdb_out, output, cdb_out_t, registered CDB payload (rd, pd, rob_idx, data, rvfi_data_out).
REQ-009 SHALL have port cdb_grant, output, [NUM_FU], registered one-hot source of cdb_out; all zero when cdb_valid is low.

Function
REQ-010 SHALL hold one result per unit in buf_valid[i] and buf_entry[i].
REQ-011 SHALL drive req_ready[i] = !buf_valid[i] || win[i], combinationally; full-and-draining accepts in the same cycle.
REQ-012 SHALL compute win (one-hot) combinationally over buf_valid: the first valid index at or after rr_ptr, modulo NUM_FU.
REQ-013 SHALL, on an edge with any win, load cdb_out from buf_entry[win], set cdb_valid=1 and cdb_grant=win, clear buf_valid[win] unless refilled that edge, and set rr_ptr=(win index+1) mod NUM_FU.
REQ-014 SHALL, on an edge with no buf_valid set, set cdb_valid=0 and cdb_grant=0, and leave rr_ptr unchanged.
REQ-015 SHALL, on an accepted transfer, set buf_valid[i]=1 and buf_entry[i]=req_entry[i]. Latency is exactly 2 edges, accept edge to cdb_valid, when uncontended.
REQ-016 SHALL broadcast at most one result per cycle; a waiting buffer is granted within NUM_FU-1 cycles of becoming valid (REQ-027 configuration).
REQ-017 SHALL, on flush high at an edge, clear all buf_valid, cdb_valid and cdb_grant, and drop that cycle's transfers; flush takes priority over accept and grant. rr_ptr is preserved.
REQ-018 SHALL force req_ready to all zero while flush is high.
REQ-019 SHALL perform no arithmetic on payload; payload passes bit-exact; rr_ptr width is $clog2(NUM_FU) and wraps from NUM_FU-1 to 0.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously clear buf_valid, cdb_valid and cdb_grant, and set rr_ptr=0.
REQ-021 SHALL zero cdb_out and buf_entry on reset; no transfer is accepted while rst_n=0.
REQ-022 SHALL resume normal operation at the first rising edge after rst_n deasserts; reset mid-broadcast discards all state.

Configuration
REQ-023 SHALL honour macro CDB_RR_ARB_EN.
REQ-024 SHALL, with CDB_RR_ARB_EN defined, use the round-robin selection of REQ-012/013.
REQ-025 SHALL, without CDB_RR_ARB_EN, use fixed priority ls>alu>mul>div>control; rr_ptr is absent and tied to 0.
REQ-026 SHALL leave the interface, latency and flush behaviour identical in both builds.
REQ-027 SHALL apply the REQ-016 bound only with CDB_RR_ARB_EN defined.

Structure
REQ-028 SHALL define NUM_FU=5 and FU index constants (FU_LS..FU_CONTROL) in package params, and take funct_unit_out_t and cdb_out_t from rv32i_types.
REQ-029 SHALL instantiate one sub-module rr_pick (parameterized width, inputs req vector and ptr, output one-hot) for the selection; the top holds buffers and registers.

Verification
REQ-030 Reset: rst_n=0 mid-stream with alu buffered -> cdb_valid=0, cdb_grant=0 immediately; after release, rr_ptr=0 and nothing is broadcast.
REQ-031 Latency: alu valid alone with rob_idx=3, data=0x1234 at edge N -> cdb_valid=1, cdb_grant=5'b00010 and same payload after edge N+1.
REQ-032 Contention: all five valid at the same edge with rr_ptr=0 -> grants on 5 consecutive cycles in order ls, alu, mul, div, control; then rr_ptr=0.
REQ-033 Fairness: ls valid every cycle, div valid once -> div granted within 2 cycles; ls and div alternate; ls never starves.
REQ-034 Backpressure: mul buffered and losing arbitration -> req_ready[2]=0; when win[2]=1, a new mul result is accepted the same edge and broadcast later.
REQ-035 Flush: flush high with 3 buffers full and a new ctrl req -> next cycle cdb_valid=0 and all req_ready=1; the dropped results never appear on the CDB.
